// File: rtl/fft_mem_ctrl.sv
// fft_mem_ctrl: address and control sequencer for a two-bank, in-place,
// radix-2 FFT. The block loads N samples into banks split by index parity.
// It then runs LOG2N butterfly stages. A PIPE-deep tap chain pairs each
// read with its write-back.
module fft_mem_ctrl #(
    parameter  int LOG2N = 6,
    parameter  int PIPE  = 1,
    parameter  int SW    = 4,
    localparam int AW    = LOG2N - 1
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          inv,
    output logic          inv_o,
    output logic          we_b0,
    output logic          we_b1,
    output logic          re_b0,
    output logic          re_b1,
    output logic [AW-1:0] waddr_b0,
    output logic [AW-1:0] waddr_b1,
    output logic [AW-1:0] raddr_b0,
    output logic [AW-1:0] raddr_b1,
    output logic          swap_in,
    output logic          swap_out,
    output logic [SW-1:0] stage,
    output logic [AW-1:0] bfly_idx,
    output logic          out_valid,
    output logic          done
);

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam int            GW     = 3;
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
    localparam logic [GW-1:0] G_LAST = GW'(PIPE - 1);

    // One read in flight: everything its write-back and twiddle lookup need
    typedef struct packed {
        logic          v;
        logic          last;
        logic          swap;
        logic [SW-1:0] stg;
        logic [AW-1:0] j;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
    } tap_t;

    logic [1:0]       state_q, state_d;
    logic             run_q, run_d;
    logic [LOG2N-1:0] k_q, k_d;
    logic [SW-1:0]    s_q, s_d;
    logic [AW-1:0]    j_q, j_d;
    logic [GW-1:0]    g_q, g_d;
    logic             gap_q, gap_d;
    logic             inv_q, inv_d;
    tap_t             tap_q [1:PIPE];
    tap_t             tap_d [1:PIPE];

    logic             rd;
    logic             last;
    logic [SW-1:0]    sh;
    logic [AW-1:0]    h;
    logic [AW-1:0]    ra0_c, ra1_c;
    logic             swap_c;
    logic             accept;
    tap_t             tap_in;

    // Read-phase address and swap decode from the stage/butterfly counters
    always_comb begin
        rd     = (state_q == ST_COMPUTE) && !gap_q;
        last   = (s_q == S_LAST);
        sh     = SW'(LOG2N - 2) - s_q;
        h      = AW'(1) << sh;
        ra0_c  = '0;
        ra1_c  = '0;
        swap_c = 1'b0;
        if (rd) begin
            ra0_c = j_q;
            if (last) begin
                ra1_c  = j_q;
                swap_c = ^j_q;
            end else begin
                ra1_c  = j_q ^ h;
                swap_c = |(j_q & h);
            end
        end
    end

    // Next-state logic: load counting, stage/butterfly/gap sequencing, tap shift
    always_comb begin
        state_d = state_q;
        run_d   = 1'b1;
        k_d     = k_q;
        s_d     = s_q;
        j_d     = j_q;
        g_d     = g_q;
        gap_d   = gap_q;
        inv_d   = inv_q;

        in_ready = run_q && ((state_q == ST_LOAD) || (state_q == ST_DONE));
        accept   = in_ready && in_valid;

        tap_in = '0;
        if (rd) begin
            tap_in.v    = 1'b1;
            tap_in.last = last;
            tap_in.swap = swap_c;
            tap_in.stg  = s_q;
            tap_in.j    = j_q;
            tap_in.ra0  = ra0_c;
            tap_in.ra1  = ra1_c;
        end
        tap_d    = tap_q;
        tap_d[1] = tap_in;
        for (int unsigned i = 2; i <= unsigned'(PIPE); i++) begin
            tap_d[i] = tap_q[i-1];
        end

        case (state_q)
            ST_LOAD, ST_DONE: begin
                // DONE always falls back to LOAD; a sample offered then is k=0
                state_d = ST_LOAD;
                if (accept) begin
                    k_d = k_q + LOG2N'(1);
                    if (k_q == '0) begin
                        inv_d = inv;
                    end
                    if (k_q == '1) begin
                        state_d = ST_COMPUTE;
                        s_d     = '0;
                        j_d     = '0;
                        g_d     = '0;
                        gap_d   = 1'b0;
                    end
                end
            end
            ST_COMPUTE: begin
                if (!gap_q) begin
                    j_d = j_q + AW'(1);
                    if (j_q == '1) begin
                        gap_d = 1'b1;
                        g_d   = '0;
                    end
                end else begin
                    g_d = g_q + GW'(1);
                    if (g_q == G_LAST) begin
                        gap_d = 1'b0;
                        g_d   = '0;
                        if (last) begin
                            state_d = ST_DONE;
                            s_d     = '0;
                        end else begin
                            s_d = s_q + SW'(1);
                        end
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Output decode: load writes come straight from k, compute writes from the last tap
    always_comb begin
        if (state_q == ST_COMPUTE) begin
            we_b0    = tap_q[PIPE].v;
            we_b1    = tap_q[PIPE].v;
            waddr_b0 = tap_q[PIPE].ra0;
            waddr_b1 = tap_q[PIPE].ra1;
        end else begin
            we_b0    = accept && !(^k_q);
            we_b1    = accept && (^k_q);
            waddr_b0 = k_q[LOG2N-1:1];
            waddr_b1 = k_q[LOG2N-1:1];
        end
        swap_out  = tap_q[PIPE].v && tap_q[PIPE].swap && !tap_q[PIPE].last;
        out_valid = tap_q[PIPE].v && tap_q[PIPE].last;
        re_b0     = rd;
        re_b1     = rd;
        raddr_b0  = ra0_c;
        raddr_b1  = ra1_c;
        swap_in   = tap_q[1].swap;
        stage     = tap_q[1].stg;
        bfly_idx  = tap_q[1].j;
        done      = (state_q == ST_DONE);
        inv_o     = inv_q;
    end

    // State, counters and tap chain; reset drops any writes still in flight
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ST_LOAD;
            run_q   <= 1'b0;
            k_q     <= '0;
            s_q     <= '0;
            j_q     <= '0;
            g_q     <= '0;
            gap_q   <= 1'b0;
            inv_q   <= 1'b0;
            tap_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            k_q     <= k_d;
            s_q     <= s_d;
            j_q     <= j_d;
            g_q     <= g_d;
            gap_q   <= gap_d;
            inv_q   <= inv_d;
            tap_q   <= tap_d;
        end
    end

endmodule

// File: tb/tb_fft_mem_ctrl.sv
// tb_fft_mem_ctrl: scoreboard bench for fft_mem_ctrl, one instance with
// LOG2N=6/PIPE=1 and one with LOG2N=4/PIPE=3.
module tb_fft_mem_ctrl;

    localparam int LA = 6;
    localparam int PA = 1;
    localparam int LB = 4;
    localparam int PB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst_a, nrst_b, in_valid, inv;

    logic          a_rdy, a_invo, a_we0, a_we1, a_re0, a_re1, a_swin, a_swout, a_ov, a_done;
    logic [LA-2:0] a_wa0, a_wa1, a_ra0, a_ra1, a_bidx;
    logic [3:0]    a_stage;
    logic          b_rdy, b_invo, b_we0, b_we1, b_re0, b_re1, b_swin, b_swout, b_ov, b_done;
    logic [LB-2:0] b_wa0, b_wa1, b_ra0, b_ra1, b_bidx;
    logic [3:0]    b_stage;

    fft_mem_ctrl #(.LOG2N(LA), .PIPE(PA), .SW(4)) u_a (
        .clk(clk), .nrst(nrst_a), .in_valid(in_valid), .in_ready(a_rdy), .inv(inv), .inv_o(a_invo),
        .we_b0(a_we0), .we_b1(a_we1), .re_b0(a_re0), .re_b1(a_re1),
        .waddr_b0(a_wa0), .waddr_b1(a_wa1), .raddr_b0(a_ra0), .raddr_b1(a_ra1),
        .swap_in(a_swin), .swap_out(a_swout), .stage(a_stage), .bfly_idx(a_bidx),
        .out_valid(a_ov), .done(a_done)
    );

    fft_mem_ctrl #(.LOG2N(LB), .PIPE(PB), .SW(4)) u_b (
        .clk(clk), .nrst(nrst_b), .in_valid(in_valid), .in_ready(b_rdy), .inv(inv), .inv_o(b_invo),
        .we_b0(b_we0), .we_b1(b_we1), .re_b0(b_re0), .re_b1(b_re1),
        .waddr_b0(b_wa0), .waddr_b1(b_wa1), .raddr_b0(b_ra0), .raddr_b1(b_ra1),
        .swap_in(b_swin), .swap_out(b_swout), .stage(b_stage), .bfly_idx(b_bidx),
        .out_valid(b_ov), .done(b_done)
    );

    // Observed outputs of whichever instance is active (the other sits in reset)
    logic        sel;
    logic        m_rdy, m_invo, m_we0, m_we1, m_re0, m_re1, m_swin, m_swout, m_ov, m_done;
    logic [11:0] m_wa0, m_wa1, m_ra0, m_ra1, m_bidx;
    logic [3:0]  m_stage;

    always_comb begin
        if (sel) begin
            {m_rdy, m_invo, m_we0, m_we1, m_re0, m_re1} = {b_rdy, b_invo, b_we0, b_we1, b_re0, b_re1};
            {m_swin, m_swout, m_ov, m_done, m_stage}   = {b_swin, b_swout, b_ov, b_done, b_stage};
            m_wa0 = 12'(b_wa0); m_wa1 = 12'(b_wa1); m_ra0 = 12'(b_ra0); m_ra1 = 12'(b_ra1);
            m_bidx = 12'(b_bidx);
        end else begin
            {m_rdy, m_invo, m_we0, m_we1, m_re0, m_re1} = {a_rdy, a_invo, a_we0, a_we1, a_re0, a_re1};
            {m_swin, m_swout, m_ov, m_done, m_stage}   = {a_swin, a_swout, a_ov, a_done, a_stage};
            m_wa0 = 12'(a_wa0); m_wa1 = 12'(a_wa1); m_ra0 = 12'(a_ra0); m_ra1 = 12'(a_ra1);
            m_bidx = 12'(a_bidx);
        end
    end

    int L, P, D;
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic b0; logic b1; int a0; int a1; logic sw; logic ov; } wr_t;
    typedef struct { int cyc; int a0; int a1; } rd_t;
    typedef struct { int cyc; logic sw; int stg; int j; } ar_t;

    wr_t wq[$];
    rd_t rq[$];
    ar_t aq[$];
    int  dq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    endtask

    function automatic logic par(input int v);
        logic r = 1'b0;
        for (int i = 0; i < 16; i++) r ^= v[i];
        return r;
    endfunction

    // Monitor: pop scoreboard entries due this cycle, flag events nobody expected
    always @(negedge clk) begin
        wr_t w;
        rd_t r;
        ar_t a;
        if (wq.size() > 0 && wq[0].cyc == cyc) begin
            w = wq.pop_front();
            chk("wr_en", {m_we0, m_we1}, {w.b0, w.b1});
            chk("wr_a0", 64'(m_wa0), 64'(w.a0));
            chk("wr_a1", 64'(m_wa1), 64'(w.a1));
            chk("swap_out", m_swout, w.sw);
            chk("out_valid", m_ov, w.ov);
        end else if (m_we0 || m_we1) begin
            chk("wr_unexp", {m_we0, m_we1}, 2'b00);
        end
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            r = rq.pop_front();
            chk("rd_en", {m_re0, m_re1}, 2'b11);
            chk("rd_a0", 64'(m_ra0), 64'(r.a0));
            chk("rd_a1", 64'(m_ra1), 64'(r.a1));
        end else if (m_re0 || m_re1) begin
            chk("rd_unexp", {m_re0, m_re1}, 2'b00);
        end
        if (aq.size() > 0 && aq[0].cyc == cyc) begin
            a = aq.pop_front();
            chk("swap_in", m_swin, a.sw);
            chk("stage", 64'(m_stage), 64'(a.stg));
            chk("bfly_idx", 64'(m_bidx), 64'(a.j));
        end
        if (dq.size() > 0 && dq[0] == cyc) begin
            void'(dq.pop_front());
            chk("done", m_done, 1'b1);
        end else if (m_done) begin
            chk("done_unexp", m_done, 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rst(input logic v);
        if (sel) nrst_b = v;
        else     nrst_a = v;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {m_rdy, m_invo, m_we0, m_we1, m_re0, m_re1, m_swin, m_swout,
                            m_ov, m_done, m_stage, m_bidx}, '0);
        chk({tag, "_addr"}, {m_wa0, m_wa1, m_ra0, m_ra1}, '0);
    endtask

    // Expected compute-phase activity, derived from the C0-relative timing formulas
    task automatic push_compute(input int c0);
        wr_t w;
        rd_t r;
        ar_t a;
        int  sh;
        for (int s = 0; s < L; s++) begin
            for (int j = 0; j < D; j++) begin
                r.cyc = c0 + s * (D + P) + j;
                r.a0  = j;
                if (s < L - 1) begin
                    sh   = L - 2 - s;
                    r.a1 = j ^ (1 << sh);
                    a.sw = ((j >> sh) & 1) != 0;
                end else begin
                    r.a1 = j;
                    a.sw = par(j);
                end
                a.cyc = r.cyc + 1;
                a.stg = s;
                a.j   = j;
                w.cyc = r.cyc + P;
                w.b0  = 1'b1;
                w.b1  = 1'b1;
                w.a0  = r.a0;
                w.a1  = r.a1;
                w.sw  = (s == L - 1) ? 1'b0 : a.sw;
                w.ov  = (s == L - 1);
                rq.push_back(r);
                aq.push_back(a);
                wq.push_back(w);
            end
        end
        dq.push_back(c0 + L * (D + P));
    endtask

    // Offer N samples; with toggle, every other cycle is idle
    task automatic load_frame(input bit toggle, input bit inv_first, output int c0);
        wr_t w;
        int  k = 0;
        int  slot = 0;
        while (k < 2 * D) begin
            if (toggle && slot[0]) begin
                in_valid = 1'b0;
                inv      = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b1;
                inv      = (k == 0) ? inv_first : ~inv_first;
                w.cyc = cyc;
                w.b0  = ~par(k);
                w.b1  = par(k);
                w.a0  = k >> 1;
                w.a1  = k >> 1;
                w.sw  = 1'b0;
                w.ov  = 1'b0;
                wq.push_back(w);
                k++;
            end
            if (slot == 0) begin
                @(negedge clk);
                chk("rdy_load", m_rdy, 1'b1);
            end
            slot++;
            tick();
        end
        in_valid = 1'b0;
        c0 = cyc;
        push_compute(c0);
    endtask

    // Walk through COMPUTE, optionally holding in_valid or resetting at c0+abort_at
    task automatic run_compute(input int c0, input bit hold, input bit inv_exp, input int abort_at);
        int tend = c0 + L * (D + P);
        while (cyc < tend) begin
            in_valid = hold;
            inv      = 1'($urandom_range(0, 1));
            if (abort_at >= 0 && cyc == c0 + abort_at) begin
                set_rst(1'b0);
                while (wq.size() > 0 && wq[$].cyc > cyc) void'(wq.pop_back());
                while (rq.size() > 0 && rq[$].cyc > cyc) void'(rq.pop_back());
                while (aq.size() > 0 && aq[$].cyc > cyc) void'(aq.pop_back());
                while (dq.size() > 0 && dq[$] > cyc) void'(dq.pop_back());
                in_valid = 1'b0;
                tick();
                @(negedge clk);
                chk_zero("rst_mid");
                set_rst(1'b1);
                tick();
                @(negedge clk);
                chk("rdy_release", m_rdy, 1'b1);
                tick();
                return;
            end
            @(negedge clk);
            if (cyc == c0) chk("rdy_compute", m_rdy, 1'b0);
            if (cyc == c0 + 3) chk("inv_o", m_invo, inv_exp);
            tick();
        end
    endtask

    task automatic reset_seq();
        in_valid = 1'b0;
        set_rst(1'b0);
        tick();
        @(negedge clk);
        chk_zero("rst");
        tick();
        set_rst(1'b1);
        @(negedge clk);
        chk("rdy_rel0", m_rdy, 1'b0);
        tick();
        @(negedge clk);
        chk("rdy_rel1", m_rdy, 1'b1);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        sel = 1'b0;
        L = LA; P = PA; D = 1 << (LA - 1);
        nrst_a = 1'b0; nrst_b = 1'b0; in_valid = 1'b0; inv = 1'b0;
        tick();
        tick();
        reset_seq();

        load_frame(1'b0, 1'b1, c0);
        run_compute(c0, 1'b1, 1'b1, -1);
        load_frame(1'b1, 1'b0, c0);
        run_compute(c0, 1'b0, 1'b0, -1);
        repeat (3) tick();
        load_frame(1'b0, 1'b1, c0);
        run_compute(c0, 1'b0, 1'b1, 50);
        load_frame(1'b0, 1'b0, c0);
        run_compute(c0, 1'b0, 1'b0, -1);
        repeat (3) tick();

        nrst_a = 1'b0;
        sel = 1'b1;
        L = LB; P = PB; D = 1 << (LB - 1);
        reset_seq();
        load_frame(1'b0, 1'b1, c0);
        run_compute(c0, 1'b1, 1'b1, -1);
        load_frame(1'b1, 1'b0, c0);
        run_compute(c0, 1'b0, 1'b0, -1);
        repeat (3) tick();

        chk("wq_drain", 64'(wq.size()), 64'd0);
        chk("rq_drain", 64'(rq.size()), 64'd0);
        chk("aq_drain", 64'(aq.size()), 64'd0);
        chk("dq_drain", 64'(dq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_mem_ctrl.md
# fft_mem_ctrl

Parametrised address and control sequencer for the two-bank in-place radix-2 FFT datapath. It loads N = 2^LOG2N samples into banks selected by index parity. It then runs LOG2N butterfly stages, reading and writing each bank at N/2 addresses, with a configurable butterfly pipeline depth. It sits between the sample source, the two dual-port bank RAMs and the butterfly/twiddle unit, and owns its own cycle counter, input handshake and done signalling.

## Interface
- LOG2N, 6, log2 of FFT size; legal 2..12. N = 2^LOG2N, D = N/2 words per bank, AW = LOG2N-1.
- PIPE, 1, write-back latency in cycles from issuing a read to the matching write; legal 1..4.
- SW, 4, stage index width; must satisfy 2^SW > LOG2N.
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- in_valid  in  1  sample present on the data path this cycle
- in_ready  out  1  block accepts samples (LOAD state)
- inv  in  1  inverse-transform request, sampled with the first accepted sample of a frame
- inv_o  out  1  latched inv for the current frame
- we_b0, we_b1  out  1  bank write enables
- re_b0, re_b1  out  1  bank read enables
- waddr_b0, waddr_b1  out  AW  bank write addresses
- raddr_b0, raddr_b1  out  AW  bank read addresses
- swap_in  out  1  exchange bank read data before the butterfly; valid when read data arrives (read cycle + 1)
- swap_out  out  1  exchange butterfly results before write; aligned with write enables
- stage  out  SW  stage of the butterfly whose read data arrives this cycle
- bfly_idx  out  AW  butterfly index j of that data, for the twiddle ROM
- out_valid  out  1  final-stage results are being written this cycle
- done  out  1  one-cycle pulse when the frame is complete

## Operation
- States: LOAD, COMPUTE, DONE. Internal counters are the sample index k (LOG2N bits), the stage index s, the butterfly index j (AW bits) and the gap counter g.
- LOAD: in_ready=1. Each cycle with in_valid=1 accepts sample k.
  - p = XOR of all bits of k.
  - we_b0 = ~p, we_b1 = p, waddr_b0 = waddr_b1 = k>>1.
  - k increments.
  - When in_valid=0, no write occurs and k holds.
  - Acceptance of k=N-1 moves the block to COMPUTE with s=0, j=0.
- COMPUTE, read phase: stage s issues D reads, j = 0..D-1, with re_b0 = re_b1 = 1.
  - s < LOG2N-1: h = 2^(AW-1-s), raddr_b0 = j, raddr_b1 = j XOR h, swap = bit (AW-1-s) of j.
  - s = LOG2N-1: raddr_b0 = raddr_b1 = j, swap = parity(j).
- COMPUTE, gap: after j = D-1, reads pause for PIPE cycles (re low, g counts) so the stage's last write lands before the next stage reads. Then s increments.
- COMPUTE, write-back: exactly PIPE cycles after each read, we_b0 = we_b1 = 1, and waddr_bX equals the raddr_bX of that read.
  - swap_out equals that read's swap, except in the final stage, where swap_out = 0.
  - out_valid is high for every final-stage write.
- Read-to-write pairing: a PIPE-deep shift register carries the read addresses, swap bits, stage and j forward to their write cycle. swap_in, stage and bfly_idx are taken from tap 1 of this shift register.
- DONE: one cycle with done=1 and in_ready=1; the block returns to LOAD with k=0. A sample offered with in_valid in this cycle is accepted as k=0.
- in_valid is ignored outside LOAD and DONE.
- Reset (nrst=0 at a clock edge, at any time including mid-frame):
  - State becomes LOAD and all counters and pipeline taps clear.
  - Every output is 0, including in_ready and inv_o.
  - in_ready rises on the first edge with nrst=1.
  - Writes still in flight are dropped.

## Timing
- C0 is the first cycle after sample N-1 is accepted.
- Stage s reads occupy cycles C0 + s(D+PIPE) + j.
- Writes occupy the read cycle + PIPE.
- The last write is at C0 + LOG2N(D+PIPE) - 1.
- done is at C0 + LOG2N(D+PIPE).
- COMPUTE length is LOG2N(D+PIPE) cycles; for LOG2N=6, PIPE=1 that is 198.
- All outputs are registered or decoded from registered state only; there is no combinational path from in_valid to any output except we_b0/we_b1 in LOAD.

## Test plan
- Reset then a continuous load of 64 samples (LOG2N=6) -> sample 5 (p=0) writes b0 addr 2; sample 7 (p=1) writes b1 addr 3; in_ready drops the cycle after k=63 is accepted.
- Load with in_valid toggling 1,0,1,0 -> k advances only on accepted samples; no writes in idle cycles; COMPUTE starts only after the 64th acceptance.
- Stage 0, LOG2N=6: j=16 -> raddr_b0=16, raddr_b1=0, swap=1. Stage 4: j=3 -> raddr_b1=2, swap=1. Final stage: j=3 -> raddr_b1=3, swap_in=0, swap_out=0.
- PIPE=3, LOG2N=4 -> the write of each read occurs 3 cycles later at the same addresses; 3-cycle read gap between stages; done at C0+44.
- nrst asserted at C0+50 -> the next cycle has all outputs 0; in_ready=1 after release; a new frame completes normally.
- inv=1 on the first sample, 0 thereafter -> inv_o=1 for the whole frame; back-to-back frames with in_valid held high across DONE -> the first sample is taken in the DONE cycle.
